store_commit_queue: RTL and testbench

//   Buffers translated stores from the store unit in two circular queues. The speculative queue holds

---
 rtl/store_commit_queue_pkg.sv | 47 ++++
 rtl/store_commit_queue.sv | 198 +++++++++++++++++++
 tb/tb_store_commit_queue.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_commit_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_queue_pkg
//  Description : Shared types for the store commit queue. These are the D$
//                request/response structs for the store port and the store
//                buffer entry layout.
//                Exports:
//                  PLEN, DCACHE_INDEX_WIDTH, DCACHE_TAG_WIDTH
//                  dcache_req_i_t  request into the D$ (driven by the queue)
//                  dcache_req_o_t  response from the D$ (grant only used here)
//                  st_buf_entry_t  one buffered store
//  Revision    : 1.0 - initial release
// ============================================================================
package store_commit_queue_pkg;

   localparam int unsigned PLEN               = 56;
   localparam int unsigned DCACHE_INDEX_WIDTH = 12;
   localparam int unsigned DCACHE_TAG_WIDTH   = PLEN - DCACHE_INDEX_WIDTH;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

   typedef struct packed {
      logic [PLEN-1:0] paddr;
      logic [63:0]     data;
      logic [7:0]      be;
      logic [1:0]      data_size;
      logic            valid;
   } st_buf_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : store_commit_queue
//  Description : Two-level store buffer. A speculative circular queue holds
//                stores that are waiting to be committed, and it is discarded
//                on flush. A committed circular queue holds retired stores and
//                drains them in order to the D$ write port. The module also
//                reports page-offset matches and pending-store status so that
//                loads can be ordered correctly.
//  Ports       :
//    clk_i, rst_ni           clock, asynchronous active-low reset
//    flush_i                 discard all speculative entries
//    valid_i / ready_o       push handshake for a new store
//    valid_without_flush_i   ungated valid, used for offset match only
//    paddr_i, data_i, be_i, data_size_i   store payload
//    commit_i                retire the oldest speculative store
//    commit_ready_o          committed queue has room
//    page_offset_i           load offset to compare (bits 11:3)
//    page_offset_matches_o   a buffered/incoming store hits that offset
//    no_st_pending_o         committed queue empty
//    store_buffer_empty_o    both queues empty
//    req_port_i / req_port_o D$ store port (grant in, write request out)
//  Revision    : 1.0 - initial release
// ============================================================================
module store_commit_queue
   import store_commit_queue_pkg::*;
#(
   parameter int unsigned DEPTH_SPEC   = 4,
   parameter int unsigned DEPTH_COMMIT = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                valid_i,
   input  logic                valid_without_flush_i,
   output logic                ready_o,
   input  logic [PLEN-1:0]     paddr_i,
   input  logic [63:0]         data_i,
   input  logic [7:0]          be_i,
   input  logic [1:0]          data_size_i,
   input  logic                commit_i,
   output logic                commit_ready_o,
   input  logic [11:0]         page_offset_i,
   output logic                page_offset_matches_o,
   output logic                no_st_pending_o,
   output logic                store_buffer_empty_o,
   input  dcache_req_o_t       req_port_i,
   output dcache_req_i_t       req_port_o
);

   localparam int unsigned SPEC_PTR_W   = $clog2(DEPTH_SPEC);
   localparam int unsigned SPEC_CNT_W   = SPEC_PTR_W + 1;
   localparam int unsigned COMMIT_PTR_W = $clog2(DEPTH_COMMIT);
   localparam int unsigned COMMIT_CNT_W = COMMIT_PTR_W + 1;

   st_buf_entry_t             spec_q   [DEPTH_SPEC];
   st_buf_entry_t             commit_q [DEPTH_COMMIT];

   logic [SPEC_PTR_W-1:0]     spec_wr_q, spec_wr_d;
   logic [SPEC_PTR_W-1:0]     spec_rd_q, spec_rd_d;
   logic [SPEC_CNT_W-1:0]     spec_cnt_q, spec_cnt_d;
   logic [COMMIT_PTR_W-1:0]   commit_wr_q, commit_wr_d;
   logic [COMMIT_PTR_W-1:0]   commit_rd_q, commit_rd_d;
   logic [COMMIT_CNT_W-1:0]   commit_cnt_q, commit_cnt_d;

   logic                      push;
   logic                      drain;
   st_buf_entry_t             head;

   // Only the grant and offset bits [11:3] matter to this block.
   logic                      unused_inputs;
   assign unused_inputs = ^{page_offset_i[2:0], req_port_i.data_rvalid, req_port_i.data_rdata};

   // A same-cycle commit frees a speculative slot, so it is credited here.
   assign ready_o        = (spec_cnt_q - SPEC_CNT_W'(commit_i)) < SPEC_CNT_W'(DEPTH_SPEC);
   assign commit_ready_o = commit_cnt_q < COMMIT_CNT_W'(DEPTH_COMMIT);

   assign push  = valid_i && ready_o && !flush_i;
   assign drain = req_port_i.data_gnt && (commit_cnt_q != '0);

   assign no_st_pending_o      = (commit_cnt_q == '0);
   assign store_buffer_empty_o = (spec_cnt_q == '0) && no_st_pending_o;

   // ---------------------------------------------------------------------
   // Pointer and counter next-state
   // ---------------------------------------------------------------------
   always_comb begin
      spec_rd_d    = spec_rd_q + SPEC_PTR_W'(commit_i);
      spec_wr_d    = spec_wr_q + SPEC_PTR_W'(push);
      spec_cnt_d   = spec_cnt_q + SPEC_CNT_W'(push) - SPEC_CNT_W'(commit_i);
      // The flush takes effect after the commit has advanced the head, so a
      // store retired in the flush cycle is not lost.
      if (flush_i) begin
         spec_wr_d  = spec_rd_d;
         spec_cnt_d = '0;
      end
      commit_wr_d  = commit_wr_q + COMMIT_PTR_W'(commit_i);
      commit_rd_d  = commit_rd_q + COMMIT_PTR_W'(drain);
      commit_cnt_d = commit_cnt_q + COMMIT_CNT_W'(commit_i) - COMMIT_CNT_W'(drain);
   end

   // ---------------------------------------------------------------------
   // State registers and entry storage
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         spec_wr_q    <= '0;
         spec_rd_q    <= '0;
         spec_cnt_q   <= '0;
         commit_wr_q  <= '0;
         commit_rd_q  <= '0;
         commit_cnt_q <= '0;
         for (int i = 0; i < DEPTH_SPEC; i++) begin
            spec_q[i] <= '0;
         end
         for (int i = 0; i < DEPTH_COMMIT; i++) begin
            commit_q[i] <= '0;
         end
      end else begin
         spec_wr_q    <= spec_wr_d;
         spec_rd_q    <= spec_rd_d;
         spec_cnt_q   <= spec_cnt_d;
         commit_wr_q  <= commit_wr_d;
         commit_rd_q  <= commit_rd_d;
         commit_cnt_q <= commit_cnt_d;

         // Clears come before sets: when full, a push reuses the slot that the
         // commit is vacating in the same cycle.
         if (commit_i) begin
            spec_q[spec_rd_q].valid <= 1'b0;
         end
         if (flush_i) begin
            for (int i = 0; i < DEPTH_SPEC; i++) begin
               spec_q[i].valid <= 1'b0;
            end
         end
         if (push) begin
            spec_q[spec_wr_q] <= '{paddr:     paddr_i,
                                   data:      data_i,
                                   be:        be_i,
                                   data_size: data_size_i,
                                   valid:     1'b1};
         end

         if (drain) begin
            commit_q[commit_rd_q].valid <= 1'b0;
         end
         if (commit_i) begin
            commit_q[commit_wr_q]       <= spec_q[spec_rd_q];
            commit_q[commit_wr_q].valid <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // D$ write request: the head of the committed queue, held until granted
   // ---------------------------------------------------------------------
   assign head = commit_q[commit_rd_q];

   always_comb begin
      req_port_o = '0;
      if (commit_cnt_q != '0) begin
         req_port_o.data_req      = 1'b1;
         req_port_o.data_we       = 1'b1;
         req_port_o.address_index = head.paddr[DCACHE_INDEX_WIDTH-1:0];
         req_port_o.address_tag   = head.paddr[DCACHE_TAG_WIDTH+DCACHE_INDEX_WIDTH-1:DCACHE_INDEX_WIDTH];
         req_port_o.data_wdata    = head.data;
         req_port_o.data_be       = head.be;
         req_port_o.data_size     = head.data_size;
      end
   end

   // ---------------------------------------------------------------------
   // Page-offset match over both queues and the incoming store
   // ---------------------------------------------------------------------
   always_comb begin
      page_offset_matches_o = valid_without_flush_i && (paddr_i[11:3] == page_offset_i[11:3]);
      for (int i = 0; i < DEPTH_SPEC; i++) begin
         if (spec_q[i].valid && (spec_q[i].paddr[11:3] == page_offset_i[11:3])) begin
            page_offset_matches_o = 1'b1;
         end
      end
      for (int i = 0; i < DEPTH_COMMIT; i++) begin
         if (commit_q[i].valid && (commit_q[i].paddr[11:3] == page_offset_i[11:3])) begin
            page_offset_matches_o = 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   commit_needs_spec_entry : assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_i |-> (spec_cnt_q != '0));
   commit_needs_room : assert property (@(posedge clk_i) disable iff (!rst_ni)
      commit_i |-> commit_ready_o);
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_commit_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_commit_queue
//  Description : Self-checking bench for store_commit_queue. A queue-based
//                reference model predicts every output each cycle. Directed
//                scenarios come first, followed by a randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_commit_queue;
   import store_commit_queue_pkg::*;

   localparam int DS = 4;
   localparam int DC = 8;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            flush_i = 1'b0;
   logic            valid_i = 1'b0;
   logic            valid_without_flush_i = 1'b0;
   logic            ready_o;
   logic [PLEN-1:0] paddr_i = '0;
   logic [63:0]     data_i = '0;
   logic [7:0]      be_i = '0;
   logic [1:0]      data_size_i = '0;
   logic            commit_i = 1'b0;
   logic            commit_ready_o;
   logic [11:0]     page_offset_i = '0;
   logic            page_offset_matches_o;
   logic            no_st_pending_o;
   logic            store_buffer_empty_o;
   dcache_req_o_t   req_port_i = '0;
   dcache_req_i_t   req_port_o;

   always #5 clk_i = ~clk_i;

   store_commit_queue #(.DEPTH_SPEC(DS), .DEPTH_COMMIT(DC)) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .flush_i               (flush_i),
      .valid_i               (valid_i),
      .valid_without_flush_i (valid_without_flush_i),
      .ready_o               (ready_o),
      .paddr_i               (paddr_i),
      .data_i                (data_i),
      .be_i                  (be_i),
      .data_size_i           (data_size_i),
      .commit_i              (commit_i),
      .commit_ready_o        (commit_ready_o),
      .page_offset_i         (page_offset_i),
      .page_offset_matches_o (page_offset_matches_o),
      .no_st_pending_o       (no_st_pending_o),
      .store_buffer_empty_o  (store_buffer_empty_o),
      .req_port_i            (req_port_i),
      .req_port_o            (req_port_o)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [PLEN-1:0] paddr;
      logic [63:0]     data;
      logic [7:0]      be;
      logic [1:0]      size;
   } ent_t;

   ent_t m_spec[$];
   ent_t m_commit[$];

   int errors = 0;
   int checks = 0;

   // staged stimulus, applied at the next falling edge
   logic            s_valid, s_vwf, s_flush, s_commit, s_gnt;
   logic [PLEN-1:0] s_paddr;
   logic [63:0]     s_data;
   logic [7:0]      s_be;
   logic [1:0]      s_size;
   logic [11:0]     s_po;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit model_match();
      bit m;
      m = s_vwf && (s_paddr[11:3] == s_po[11:3]);
      foreach (m_spec[i])   if (m_spec[i].paddr[11:3]   == s_po[11:3]) m = 1'b1;
      foreach (m_commit[i]) if (m_commit[i].paddr[11:3] == s_po[11:3]) m = 1'b1;
      return m;
   endfunction

   function automatic dcache_req_i_t model_req();
      dcache_req_i_t r;
      r = '0;
      if (m_commit.size() > 0) begin
         r.data_req      = 1'b1;
         r.data_we       = 1'b1;
         r.address_index = m_commit[0].paddr[11:0];
         r.address_tag   = m_commit[0].paddr[PLEN-1:12];
         r.data_wdata    = m_commit[0].data;
         r.data_be       = m_commit[0].be;
         r.data_size     = m_commit[0].size;
      end
      return r;
   endfunction

   task automatic idle();
      s_valid = 1'b0; s_vwf = 1'b0; s_flush = 1'b0; s_commit = 1'b0; s_gnt = 1'b0;
      s_paddr = '0; s_data = '0; s_be = '0; s_size = '0; s_po = '0;
   endtask

   task automatic apply();
      flush_i               = s_flush;
      valid_i               = s_valid;
      valid_without_flush_i = s_vwf;
      paddr_i               = s_paddr;
      data_i                = s_data;
      be_i                  = s_be;
      data_size_i           = s_size;
      commit_i              = s_commit;
      page_offset_i         = s_po;
      req_port_i            = '0;
      req_port_i.data_gnt   = s_gnt;
   endtask

   // One clock: apply staged inputs, compare every output with the model,
   // then advance the model as the rising edge will advance the DUT.
   task automatic cycle();
      bit   exp_ready;
      ent_t e;
      if (m_spec.size() == 0 || m_commit.size() >= DC) s_commit = 1'b0;
      @(negedge clk_i);
      apply();
      #1;
      exp_ready = (m_spec.size() - int'(s_commit)) < DS;
      check("ready",        256'(ready_o),               256'(exp_ready));
      check("commit_ready", 256'(commit_ready_o),        256'(m_commit.size() < DC));
      check("no_st_pend",   256'(no_st_pending_o),       256'(m_commit.size() == 0));
      check("sb_empty",     256'(store_buffer_empty_o),  256'(m_spec.size() == 0 && m_commit.size() == 0));
      check("match",        256'(page_offset_matches_o), 256'(model_match()));
      check("req",          256'(req_port_o),            256'(model_req()));
      if (s_gnt && m_commit.size() > 0) void'(m_commit.pop_front());
      if (s_commit) m_commit.push_back(m_spec.pop_front());
      if (s_flush) m_spec.delete();
      else if (s_valid && exp_ready) begin
         e.paddr = s_paddr; e.data = s_data; e.be = s_be; e.size = s_size;
         m_spec.push_back(e);
      end
   endtask

   task automatic push(input logic [PLEN-1:0] pa, input bit cm, input bit gn);
      idle();
      s_valid = 1'b1; s_vwf = 1'b1; s_paddr = pa;
      s_data  = {$urandom, $urandom};
      s_be    = 8'($urandom);
      s_size  = 2'($urandom);
      s_commit = cm; s_gnt = gn;
      cycle();
   endtask

   task automatic tick(input bit cm, input bit gn, input bit fl);
      idle();
      s_commit = cm; s_gnt = gn; s_flush = fl;
      cycle();
   endtask

   // Quiet cycle (no push/commit/grant) used for extra point checks.
   task automatic probe(input logic [11:0] po);
      idle();
      s_po = po;
      @(negedge clk_i);
      apply();
      #1;
   endtask

   task automatic drain_all();
      for (int k = 0; k < 64 && (m_spec.size() + m_commit.size()) > 0; k++)
         tick(m_spec.size() > 0 && m_commit.size() < DC, 1'b1, 1'b0);
      probe(12'h0);
      check("drained_empty", 256'(store_buffer_empty_o), 256'(1));
   endtask

   initial begin
      idle();
      apply();
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready",   256'(ready_o),               256'(1));
      check("rst_cready",  256'(commit_ready_o),        256'(1));
      check("rst_nsp",     256'(no_st_pending_o),       256'(1));
      check("rst_empty",   256'(store_buffer_empty_o),  256'(1));
      check("rst_match",   256'(page_offset_matches_o), 256'(0));
      check("rst_req",     256'(req_port_o),            256'(0));
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: single store, commit, then drain with grant held
      push(56'h80001008, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      probe(12'h0);
      check("t1_req_after_commit", 256'(req_port_o.data_req), 256'(1));
      check("t1_req_index",        256'(req_port_o.address_index), 256'(12'h008));
      tick(1'b0, 1'b1, 1'b0);
      probe(12'h0);
      check("t1_nsp_after_gnt", 256'(no_st_pending_o), 256'(1));

      // 2: fill the speculative queue, then push+commit together
      for (int i = 0; i < 4; i++) push(56'h1000 + 56'(i * 8), 1'b0, 1'b0);
      probe(12'h0);
      check("t2_full_ready", 256'(ready_o), 256'(0));
      push(56'h2000, 1'b1, 1'b0);
      probe(12'h0);
      check("t2_still_full", 256'(ready_o), 256'(0));
      drain_all();

      // 3: flush with a committed store in flight
      for (int i = 0; i < 3; i++) push(56'h3000 + 56'(i * 8), 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      probe(12'h0);
      check("t3_ready_after_flush", 256'(ready_o), 256'(1));
      check("t3_committed_kept",    256'(store_buffer_empty_o), 256'(0));
      tick(1'b0, 1'b1, 1'b0);
      probe(12'h0);
      check("t3_empty_after_gnt", 256'(store_buffer_empty_o), 256'(1));

      // 4: fill the committed queue without grants
      push(56'h4000, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) push(56'h4000 + 56'(i * 8), 1'b1, 1'b0);
      probe(12'h0);
      check("t4_commit_full", 256'(commit_ready_o), 256'(0));
      check("t4_head_index",  256'(req_port_o.address_index), 256'(12'h000));
      probe(12'h0);
      check("t4_head_stable", 256'(req_port_o.address_index), 256'(12'h000));
      tick(1'b0, 1'b1, 1'b0);
      probe(12'h0);
      check("t4_room_after_gnt", 256'(commit_ready_o), 256'(1));
      drain_all();

      // 5: page-offset match boundaries
      push(56'h2D08, 1'b0, 1'b0);
      probe(12'hD0F);
      check("t5_match_hit",  256'(page_offset_matches_o), 256'(1));
      probe(12'hD10);
      check("t5_match_miss", 256'(page_offset_matches_o), 256'(0));
      drain_all();

      // 6: asynchronous reset while draining
      push(56'h6000, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) push(56'h6000 + 56'(i * 8), 1'b1, 1'b0);
      @(negedge clk_i);
      idle();
      apply();
      #2 rst_ni = 1'b0;
      #1;
      check("t6_nsp",   256'(no_st_pending_o),      256'(1));
      check("t6_req",   256'(req_port_o.data_req),  256'(0));
      check("t6_empty", 256'(store_buffer_empty_o), 256'(1));
      check("t6_ready", 256'(ready_o),              256'(1));
      m_spec.delete();
      m_commit.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;

      // randomized traffic: low grant rate first to fill, then higher
      for (int n = 0; n < 600; n++) begin
         idle();
         s_vwf    = 1'($urandom_range(0, 1));
         s_valid  = s_vwf;
         s_flush  = ($urandom_range(0, 15) == 0);
         s_commit = 1'($urandom_range(0, 1));
         s_gnt    = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
         s_paddr  = PLEN'({$urandom, $urandom});
         s_paddr[11:3] = 9'h1A0 + 9'($urandom_range(0, 7));
         s_data   = {$urandom, $urandom};
         s_be     = 8'($urandom);
         s_size   = 2'($urandom);
         s_po     = {9'h1A0 + 9'($urandom_range(0, 7)), 3'($urandom)};
         cycle();
      end
      drain_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
